// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing the CPU RAM port with one secondary (DMA) master.
// Optional DMA bursts are built when MEM_ARB_BURST_EN is defined.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic        cpu_be,
    output logic        cpu_wait,
    output logic [15:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_be,
    input  logic        dma_lock,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] dma_rdata,

    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    output logic        ram_be,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [0:0] {
        OwnCpu,
        OwnDma
    } owner_e;

    localparam logic [3:0] WaitLimit = 4'(MAX_WAIT);
    localparam logic [3:0] BeatLast  = 4'(BURST_MAX - 1);

    owner_e     owner_q, owner_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       dma_rvalid_q, dma_rvalid_d;

    logic       cpu_busy;
    logic       dma_beat;
    logic       grant_start;
    logic       hold_grant;

    assign cpu_busy = cpu_re | cpu_we;
    assign dma_beat = (owner_q == OwnDma) & dma_req;

`ifdef MEM_ARB_BURST_EN
    logic [3:0] beat_cnt_q, beat_cnt_d;

    // A locked beat keeps the port only while the burst has beats left.
    assign hold_grant = dma_beat & dma_lock & (beat_cnt_q < BeatLast);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (grant_start) begin
            beat_cnt_d = '0;
        end else if (dma_beat) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    logic unused_burst;

    assign unused_burst = ^{dma_lock, BeatLast};
    assign hold_grant   = 1'b0;
`endif

    // Ownership and starvation counter.
    always_comb begin
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        grant_start = 1'b0;
        unique case (owner_q)
            OwnCpu: begin
                if (dma_req && (!cpu_busy || wait_cnt_q == WaitLimit)) begin
                    owner_d     = OwnDma;
                    grant_start = 1'b1;
                    wait_cnt_d  = '0;
                end else if (!dma_req) begin
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < WaitLimit) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            OwnDma: begin
                // Never re-granted on the same edge, so the CPU always gets a cycle.
                if (!hold_grant) begin
                    owner_d = OwnCpu;
                end
                if (!dma_req) begin
                    wait_cnt_d = '0;
                end
            end
            default: begin
                owner_d    = OwnCpu;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign dma_rvalid_d = dma_beat & ~dma_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OwnCpu;
            wait_cnt_q   <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Port mux: the CPU path is purely combinational so it sees no added latency.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        ram_re    = cpu_re;
        ram_be    = cpu_be;
        cpu_wait  = 1'b0;
        dma_gnt   = 1'b0;
        if (owner_q == OwnDma) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_req & dma_we;
            ram_re    = dma_req & ~dma_we;
            ram_be    = dma_be;
            cpu_wait  = cpu_busy;
            dma_gnt   = 1'b1;
        end
    end

    assign cpu_rdata  = ram_rdata;
    assign dma_rdata  = ram_rdata;
    assign dma_rvalid = dma_rvalid_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single RAM port of the 16-bit CPU. It shares the port between the CPU and one secondary bus master (DMA, for example the UART receive engine). The CPU is the default owner and sees zero added latency when it owns the port. The secondary master is granted idle slots, is granted forcibly after a bounded wait, and can optionally hold the port for a short burst.

## Interface
Parameters:
- MAX_WAIT, 4: cycles a pending DMA request may be blocked before it preempts the CPU. Range 1..15.
- BURST_MAX, 4: maximum DMA beats per grant when bursts are enabled. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- cpu_addr  in  16  CPU byte address
- cpu_wdata  in  16  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_re  in  1  CPU read strobe
- cpu_be  in  1  CPU byte-enable (byte access)
- cpu_wait  out  1  CPU must hold its current access and retry
- cpu_rdata  out  16  read data returned to the CPU
- dma_req  in  1  DMA wants a beat this cycle
- dma_we  in  1  beat is a write (otherwise a read)
- dma_be  in  1  byte-enable for the DMA beat
- dma_lock  in  1  request that the grant be held for the following beat
- dma_addr  in  16  DMA byte address
- dma_wdata  in  16  DMA write data
- dma_gnt  out  1  DMA owns the port this cycle
- dma_rvalid  out  1  dma_rdata is valid this cycle
- dma_rdata  out  16  read data returned to the DMA
- ram_addr  out  16  RAM address
- ram_wdata  out  16  RAM write data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_be  out  1  RAM byte-enable
- ram_rdata  in  16  RAM read data

## Operation
- A registered owner bit selects between two states, OWN_CPU and OWN_DMA. Reset forces OWN_CPU.
- **OWN_CPU:**
  - ram_* follow the cpu_* inputs combinationally.
  - cpu_wait = 0.
  - dma_gnt = 0.
- **OWN_DMA:**
  - ram_addr, ram_wdata and ram_be come from the dma_* inputs.
  - ram_we = dma_req & dma_we.
  - ram_re = dma_req & ~dma_we.
  - cpu_wait = cpu_re | cpu_we.
  - dma_gnt = 1.
- **Transition OWN_CPU -> OWN_DMA** happens at the next edge when dma_req=1 and either of these holds:
  - (cpu_re|cpu_we)=0, which is an idle slot, or
  - wait_cnt == MAX_WAIT, which is a forced preemption.
- **Transition OWN_DMA -> OWN_CPU** happens at the next edge unless the current cycle is a locked beat: dma_req=1, dma_lock=1 and beat_cnt < BURST_MAX-1.
- **wait_cnt:**
  - It is 4 bits wide.
  - It increments in each OWN_CPU cycle where dma_req=1, saturating at MAX_WAIT.
  - It clears on entry to OWN_DMA.
  - It clears in any cycle with dma_req=0.
- **beat_cnt:**
  - It is 4 bits wide.
  - It clears on entry to OWN_DMA.
  - It increments on each granted beat.
- **Read return:**
  - cpu_rdata = ram_rdata and dma_rdata = ram_rdata, both unregistered pass-through.
  - dma_rvalid is a registered flag. It is set one cycle after an OWN_DMA cycle with ram_re=1, and is 0 otherwise.
- **Granted cycle with dma_req=0:** the slot is idle (ram_re=ram_we=0), and the owner returns to OWN_CPU.

## Timing
- Reset values:
  - owner = OWN_CPU
  - dma_gnt = 0, dma_rvalid = 0, cpu_wait = 0
  - wait_cnt = 0, beat_cnt = 0
  - ram_we/ram_re follow the CPU inputs
- CPU latency: 0 added cycles while it owns the port.
- DMA grant latency:
  - 1 cycle after dma_req when the CPU is idle.
  - At most MAX_WAIT+1 cycles under continuous CPU traffic.
- DMA read data is valid one cycle after the beat, together with dma_rvalid.
- Bursts:
  - A locked burst occupies at most BURST_MAX consecutive cycles.
  - The CPU always gets at least one cycle between grants, because OWN_DMA -> OWN_CPU is never followed by the same-edge re-grant.
  - After a grant ends, wait_cnt restarts from 0.
- Reset asserted mid-burst: owner returns to OWN_CPU at that edge, and any dma_rvalid pending for the next cycle is suppressed.
- A dma_req that deasserts while waiting clears wait_cnt; no grant is issued.

## Configuration
- Macro MEM_ARB_BURST_EN.
- When defined, dma_lock is honoured up to BURST_MAX beats.
- When undefined:
  - dma_lock is ignored.
  - Every grant is exactly one cycle.
  - beat_cnt is not built.

## Test plan
- **Reset:** hold reset for 2 cycles with dma_req=1.
  - Expect dma_gnt=0, cpu_wait=0 and dma_rvalid=0.
  - Expect ram_addr == cpu_addr (0x0100).
- **Idle-slot grant:**
  - Stimulus: cpu_re=cpu_we=0, dma_req=1, dma_we=0, dma_addr=0x2000, RAM returns 0xBEEF.
  - Expect dma_gnt on the next cycle and ram_re=1 with ram_addr=0x2000.
  - Expect dma_rvalid=1 with dma_rdata=0xBEEF one cycle later.
- **Starvation preemption:** cpu_re=1 every cycle, dma_req=1, MAX_WAIT=4.
  - Expect dma_gnt exactly 5 cycles after dma_req rises.
  - Expect cpu_wait=1 for that one cycle, then dma_gnt=0 and cpu_wait=0.
- **Burst** (MEM_ARB_BURST_EN, BURST_MAX=4): dma_lock=1, dma_we=1, writes to 0x3000..0x3006.
  - Expect 4 consecutive ram_we cycles, then one OWN_CPU cycle.
  - Repeat without the macro: expect single-beat grants separated by CPU cycles.
- **Reset mid-burst:** assert reset during the 2nd read beat of a burst.
  - Expect dma_gnt=0 and no dma_rvalid on the following cycle.
- **Request withdrawal:** dma_req high for 2 cycles under CPU traffic, then low.
  - Expect no grant and wait_cnt back at 0.
  - A new request must then wait the full MAX_WAIT again.
